// File: rtl/zcted_timing_pkg.sv
// Shared constants and helpers for the ZCTED timing-recovery chain.
// Fixed-point conventions: mu is unsigned Q0.MU_F, and 1.0 = 2^MU_F.
package zcted_timing_pkg;

  localparam int MU_F_DEF = 9;

  typedef logic [MU_F_DEF-1:0] mu_t;

  function automatic int ONE(input int mu_f);
    return 1 << mu_f;
  endfunction

  function automatic int HALF(input int mu_f);
    return 1 << (mu_f - 1);
  endfunction

  // Saturating cast of a signed value into the unsigned range [0, 2^bits-1].
  function automatic int sat_u(input int x, input int bits);
    int hi;
    hi = (1 << bits) - 1;
    if (x < 0) return 0;
    if (x > hi) return hi;
    return x;
  endfunction

endpackage

// File: rtl/timing_nco_mc_if.sv
// Sample-in / result-out bundle of the multi-channel timing NCO.
interface timing_nco_mc_if #(
  parameter int NCH  = 4,
  parameter int MU_F = 9,
  parameter int V_W  = 16
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  logic                  in_valid;
  logic [CW-1:0]         in_ch;
  logic signed [V_W-1:0] v_k;
  logic [MU_F-1:0]       step;
  logic                  clr_en;
  logic [CW-1:0]         clr_ch;

  logic                  out_valid;
  logic [CW-1:0]         out_ch;
  logic [MU_F-1:0]       mu;
  logic                  strobe;
  logic                  clamp;
  logic [NCH-1:0]        clamp_sticky;

  modport master (
    output in_valid, in_ch, v_k, step, clr_en, clr_ch,
    input  out_valid, out_ch, mu, strobe, clamp, clamp_sticky
  );

  modport slave (
    input  in_valid, in_ch, v_k, step, clr_en, clr_ch,
    output out_valid, out_ch, mu, strobe, clamp, clamp_sticky
  );

endinterface

// File: rtl/nco_inc_sat.sv
// NCO increment: scale the loop-filter word to mu resolution, add the nominal
// step and saturate into [0, 1.0). Purely combinational, shared with the 1-ch loop.
module nco_inc_sat
  import zcted_timing_pkg::*;
#(
  parameter int MU_F = 9,
  parameter int V_W  = 16
) (
  input  logic signed [V_W-1:0] v_k,
  input  logic [MU_F-1:0]       step,
  output logic [MU_F-1:0]       w_sat,
  output logic                  clamp
);

  localparam int SH = V_W - 1 - MU_F;
  localparam int WW = (V_W > MU_F + 2) ? V_W : MU_F + 2;

  logic signed [WW-1:0]   v_wide;
  logic signed [MU_F+1:0] v_s;
  logic signed [MU_F+1:0] w;
  int                     w_i;
  int                     s_i;

  // v_s spans [-2^MU_F, 2^MU_F-1], so MU_F+2 signed bits hold both it and the sum.
  always_comb begin
    v_wide = WW'(v_k);
    v_s    = (MU_F + 2)'(v_wide >>> SH);
    w      = {2'b00, step} + v_s;
    w_i    = int'(w);
    s_i    = sat_u(w_i, MU_F);
    w_sat  = MU_F'(s_i);
    clamp  = (s_i != w_i);
  end

endmodule

// File: rtl/timing_nco_mc.sv
// Multi-channel timing-recovery NCO: stage 1 forms the saturated increment,
// stage 2 does the per-channel accumulate/wrap and reports mu and the symbol strobe.
module timing_nco_mc
  import zcted_timing_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int MU_F    = 9,
  parameter int V_W     = 16,
  parameter int MU_INIT = 154
) (
  input  logic           clk,
  input  logic           rst,
  timing_nco_mc_if.slave bus
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [MU_F-1:0] MU_RST = MU_F'(MU_INIT);

  logic                       in_ok;
  logic                       clr_ok;
  logic [MU_F-1:0]            w_nxt;
  logic                       clamp_nxt;

  logic                       valid1;
  logic [CW-1:0]              ch1;
  logic [MU_F-1:0]            w1;
  logic                       clamp1;

  logic [NCH-1:0][MU_F-1:0]   acc;
  logic [NCH-1:0]             sticky;
  logic [MU_F:0]              sum;
  logic [MU_F-1:0]            acc_new;
  logic                       wrap;

  logic                       out_valid_q;
  logic [CW-1:0]              out_ch_q;
  logic [MU_F-1:0]            mu_q;
  logic                       strobe_q;
  logic                       clamp_q;

  // Out-of-range channel indices are dropped silently.
  always_comb begin
    in_ok  = bus.in_valid && (int'(bus.in_ch) < NCH);
    clr_ok = bus.clr_en && (int'(bus.clr_ch) < NCH);
  end

  nco_inc_sat #(
    .MU_F (MU_F),
    .V_W  (V_W)
  ) u_inc (
    .v_k   (bus.v_k),
    .step  (bus.step),
    .w_sat (w_nxt),
    .clamp (clamp_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid1 <= 1'b0;
      ch1    <= '0;
      w1     <= '0;
      clamp1 <= 1'b0;
    end else begin
      valid1 <= in_ok;
      if (in_ok) begin
        ch1    <= bus.in_ch;
        w1     <= w_nxt;
        clamp1 <= clamp_nxt;
      end
    end
  end

  // w1 < 1.0, so at most one wrap per update and the low bits are the remainder.
  always_comb begin
    sum     = {1'b0, acc[ch1]} + {1'b0, w1};
    wrap    = sum[MU_F];
    acc_new = sum[MU_F-1:0];
  end

  // Clear is applied after the stage-2 write so it wins on a same-channel collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) acc[i] <= MU_RST;
      sticky <= '0;
    end else begin
      if (valid1) begin
        acc[ch1] <= acc_new;
        if (clamp1) sticky[ch1] <= 1'b1;
      end
      if (clr_ok) begin
        acc[bus.clr_ch]    <= MU_RST;
        sticky[bus.clr_ch] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      mu_q        <= '0;
      strobe_q    <= 1'b0;
      clamp_q     <= 1'b0;
    end else begin
      out_valid_q <= valid1;
      if (valid1) begin
        out_ch_q <= ch1;
        mu_q     <= acc_new;
        strobe_q <= wrap;
        clamp_q  <= clamp1;
      end
    end
  end

  always_comb begin
    bus.out_valid    = out_valid_q;
    bus.out_ch       = out_ch_q;
    bus.mu           = mu_q;
    bus.strobe       = strobe_q;
    bus.clamp        = clamp_q;
    bus.clamp_sticky = sticky;
  end

endmodule

// File: tb/tb_timing_nco_mc.sv
// Randomised bench for timing_nco_mc against an arithmetic per-channel model.
module tb_timing_nco_mc;

  localparam int NCH     = 4;
  localparam int MU_F    = 9;
  localparam int V_W     = 16;
  localparam int MU_INIT = 154;
  localparam int CW      = 2;
  localparam int ONE_V   = 1 << MU_F;
  localparam int DIV     = 1 << (V_W - 1 - MU_F);
  localparam int OW      = 1 + CW + MU_F + 2 + NCH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  timing_nco_mc_if #(.NCH(NCH), .MU_F(MU_F), .V_W(V_W)) bus ();

  timing_nco_mc #(.NCH(NCH), .MU_F(MU_F), .V_W(V_W), .MU_INIT(MU_INIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: one accumulator per channel plus the sample sitting in stage 1.
  int             acc_m[NCH];
  logic [NCH-1:0] sticky_m;
  bit             p_v;
  int             p_ch, p_ws;
  bit             p_cl;
  logic [OW-1:0]  e_obs;
  int             e_mu;
  bit             e_str;

  function automatic int vs_of(input int vk);
    if (vk >= 0) return vk / DIV;
    return -((-vk + DIV - 1) / DIV);
  endfunction

  function automatic logic [OW-1:0] obs();
    return {bus.out_valid,
            bus.out_valid ? {bus.out_ch, bus.mu, bus.strobe, bus.clamp} : {(CW+MU_F+2){1'b0}},
            bus.clamp_sticky};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) acc_m[i] = MU_INIT;
    sticky_m = '0;
    p_v      = 1'b0;
    e_obs    = '0;
  endtask

  // Drive one cycle, advance the model across the edge, leave time at edge+1.
  task automatic cyc(input bit iv, input int ch, input int vk, input int st,
                     input bit ce, input int cc);
    int s, w;
    bus.in_valid = iv;
    bus.in_ch    = ch[CW-1:0];
    bus.v_k      = vk[V_W-1:0];
    bus.step     = st[MU_F-1:0];
    bus.clr_en   = ce;
    bus.clr_ch   = cc[CW-1:0];
    @(posedge clk);
    if (p_v) begin
      s     = acc_m[p_ch] + p_ws;
      e_str = (s >= ONE_V);
      e_mu  = s % ONE_V;
      acc_m[p_ch] = e_mu;
      if (p_cl) sticky_m[p_ch] = 1'b1;
    end
    if (ce) begin
      acc_m[cc]    = MU_INIT;
      sticky_m[cc] = 1'b0;
    end
    e_obs = p_v ? {1'b1, CW'(p_ch), MU_F'(e_mu), e_str, p_cl, sticky_m}
                : {1'b0, {(CW+MU_F+2){1'b0}}, sticky_m};
    p_v = iv && (ch < NCH);
    if (p_v) begin
      w    = st + vs_of(vk);
      p_cl = (w < 0) || (w > ONE_V - 1);
      p_ws = (w < 0) ? 0 : ((w > ONE_V - 1) ? ONE_V - 1 : w);
      p_ch = ch;
    end
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_tests++;
    if ({bus.out_valid, bus.out_ch, bus.mu, bus.strobe, bus.clamp, bus.clamp_sticky} !== '0) begin
      n_fail++;
      $display("FAIL reset_state got ov=%b ch=%0d mu=%0d st=%b cl=%b sticky=%b req all zero",
               bus.out_valid, bus.out_ch, bus.mu, bus.strobe, bus.clamp, bus.clamp_sticky);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic test_nominal();
    int lit_mu[4] = '{410, 154, 410, 154};
    bit lit_s[4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
    int k = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(i < 4, 0, 0, 256, 1'b0, 0);
      n_tests++;
      if (obs() !== e_obs) begin
        n_fail++;
        $display("FAIL nominal_model cyc %0d got %h req %h", i, obs(), e_obs);
      end
      if (bus.out_valid === 1'b1 && k < 4) begin
        n_tests++;
        if (int'(bus.mu) != lit_mu[k] || bus.strobe !== lit_s[k]) begin
          n_fail++;
          $display("FAIL nominal_value #%0d got mu=%0d st=%b req mu=%0d st=%b",
                   k, bus.mu, bus.strobe, lit_mu[k], lit_s[k]);
        end
        k++;
      end
    end
    n_tests++;
    if (k != 4) begin
      n_fail++;
      $display("FAIL nominal_count got %0d outputs req 4", k);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 4; i++) begin
      cyc(i == 0 || i == 2, 0, (i == 0) ? -32768 : 32767, 256, 1'b0, 0);
      n_tests++;
      if (obs() !== e_obs) begin
        n_fail++;
        $display("FAIL sat_model cyc %0d got %h req %h", i, obs(), e_obs);
      end
      if (i == 1) begin
        n_tests++;
        if ({bus.mu, bus.clamp, bus.strobe, bus.clamp_sticky[0]} !== {9'd154, 1'b1, 1'b0, 1'b1}) begin
          n_fail++;
          $display("FAIL neg_sat got mu=%0d cl=%b st=%b sticky0=%b req mu=154 cl=1 st=0 sticky0=1",
                   bus.mu, bus.clamp, bus.strobe, bus.clamp_sticky[0]);
        end
      end
      if (i == 3) begin
        n_tests++;
        if ({bus.mu, bus.clamp, bus.strobe} !== {9'd153, 1'b1, 1'b1}) begin
          n_fail++;
          $display("FAIL pos_sat got mu=%0d cl=%b st=%b req mu=153 cl=1 st=1",
                   bus.mu, bus.clamp, bus.strobe);
        end
      end
    end
  endtask

  task automatic test_interleave();
    int vk_tab[4] = '{0, 64, -64, 0};
    int lit_il[4] = '{154, 156, 152, 154};
    int k = 0;
    for (int i = 0; i < NCH; i++) cyc(1'b0, 0, 0, 256, 1'b1, i);
    for (int i = 0; i < 10; i++) begin
      cyc(i < 8, i % 4, vk_tab[i % 4], 256, 1'b0, 0);
      n_tests++;
      if (obs() !== e_obs) begin
        n_fail++;
        $display("FAIL interleave_model cyc %0d got %h req %h", i, obs(), e_obs);
      end
      if (bus.out_valid === 1'b1) begin
        if (k >= 4) begin
          n_tests++;
          if (int'(bus.mu) != lit_il[k-4] || bus.strobe !== 1'b1 || int'(bus.out_ch) != k % 4) begin
            n_fail++;
            $display("FAIL interleave_value #%0d got ch=%0d mu=%0d st=%b req ch=%0d mu=%0d st=1",
                     k, bus.out_ch, bus.mu, bus.strobe, k % 4, lit_il[k-4]);
          end
        end
        k++;
      end
    end
  endtask

  task automatic test_back_to_back();
    int vk;
    bit ce;
    cyc(1'b0, 0, 0, 256, 1'b1, 2);
    for (int i = 0; i < 60; i++) begin
      vk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535)) - 32768
                                       : int'($urandom_range(0, 4000)) - 2000;
      ce = (i == 20) || ($urandom_range(0, 7) == 0);
      cyc(i < 58, 2, vk, int'($urandom_range(200, 320)), ce, (i == 20) ? 2 : int'($urandom_range(0, 3)));
      n_tests++;
      if (obs() !== e_obs) begin
        n_fail++;
        $display("FAIL back_to_back cyc %0d got %h req %h", i, obs(), e_obs);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      cyc($urandom_range(0, 3) != 0, int'($urandom_range(0, NCH - 1)),
          int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, ONE_V - 1)),
          $urandom_range(0, 9) == 0, int'($urandom_range(0, NCH - 1)));
      n_tests++;
      if (obs() !== e_obs) begin
        n_fail++;
        $display("FAIL random cyc %0d got %h req %h", i, obs(), e_obs);
      end
    end
  endtask

  task automatic test_reset_mid();
    cyc(1'b1, 1, 3000, 300, 1'b0, 0);
    cyc(1'b1, 3, -3000, 100, 1'b0, 0);
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.mu !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_async got ov=%b mu=%0d req ov=0 mu=0", bus.out_valid, bus.mu);
    end
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    for (int i = 0; i < NCH + 5; i++) begin
      cyc(i >= 3 && i < 3 + NCH, (i - 3) & (NCH - 1), 0, 0, 1'b0, 0);
      n_tests++;
      if (obs() !== e_obs) begin
        n_fail++;
        $display("FAIL reset_mid_model cyc %0d got %h req %h", i, obs(), e_obs);
      end
      if (bus.out_valid === 1'b1) begin
        n_tests++;
        if (int'(bus.mu) != MU_INIT || i < 4) begin
          n_fail++;
          $display("FAIL reset_mid_acc cyc %0d got ov=%b mu=%0d req mu=%0d", i, bus.out_valid, bus.mu, MU_INIT);
        end
      end
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_ch    = '0;
    bus.v_k      = '0;
    bus.step     = '0;
    bus.clr_en   = 1'b0;
    bus.clr_ch   = '0;
    model_reset();
    test_reset();
    test_nominal();
    test_saturation();
    test_interleave();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/timing_nco_mc.md
# timing_nco_mc

Multi-channel, parameterised timing-recovery NCO for the ZCTED symbol-sync chain. It sits between the per-channel loop filter and the interpolator. For each channel it accumulates a nominal step plus the scaled loop-filter correction into a fractional-interval register `mu`. It issues a symbol strobe on every wrap through 1.0 and flags saturated increments. Channels are time-multiplexed on one input stream, so the block holds per-channel state and exposes a two-stage pipeline with valid tagging.

## Interface
- `NCH`, default 4: number of channels, ≥1; `CW = max(1, $clog2(NCH))`.
- `MU_F`, default 9: fractional bits of `mu`; 1.0 = 2^MU_F.
- `V_W`, default 16: loop-filter word width, signed Q1.(V_W-1); requires V_W-1 ≥ MU_F.
- `MU_INIT`, default 154: reset/clear value of every channel accumulator (≈0.3).
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  sample strobe for `in_ch`.
- `in_ch`  in  CW  channel index of the current sample.
- `v_k`  in  V_W  signed loop-filter output, Q1.(V_W-1).
- `step`  in  MU_F  unsigned nominal increment (256 = 0.5 → 2 samples/symbol), quasi-static.
- `clr_en`  in  1  clear request for channel `clr_ch`.
- `clr_ch`  in  CW  channel to clear.
- `out_valid`  out  1  result valid.
- `out_ch`  out  CW  channel of the result.
- `mu`  out  MU_F  updated fractional interval of `out_ch`.
- `strobe`  out  1  accumulator wrapped on this update (symbol boundary).
- `clamp`  out  1  increment was saturated on this update.
- `clamp_sticky`  out  NCH  per-channel sticky saturation flags.

## Operation
- **Stage 1** (registered on `in_valid`):
  - `v_s = v_k >>> (V_W-1-MU_F)`, arithmetic shift.
  - `w = step + v_s`, computed signed at MU_F+2 bits.
  - Saturate `w` to [0, 2^MU_F - 1]. If either limit is hit, latch `clamp1 = 1`.
  - Register `w_sat`, `ch`, `clamp1`, `valid1`.
- **Stage 2** (read-modify-write of `acc[ch]`, MU_F+1-bit sum):
  - `sum = acc[ch] + w_sat`.
  - If `sum ≥ 2^MU_F`: write `acc[ch] = sum - 2^MU_F` and set `strobe = 1`.
  - Otherwise: write `acc[ch] = sum[MU_F-1:0]` and set `strobe = 0`.
  - Because `w_sat < 1.0`, at most one wrap is possible per update.
  - Outputs: `mu` = new `acc[ch]`, `out_ch = ch`, `clamp = clamp1`, `out_valid = 1`.
  - If `clamp1 = 1`, set `clamp_sticky[ch]`.
- **No valid input:** with `in_valid = 0` no state changes. `out_valid` drops 2 cycles later; `mu`, `out_ch` and `strobe` hold their values, but `strobe` and `clamp` are qualified by `out_valid`.
- **Clear:** `clr_en` sets `acc[clr_ch] = MU_INIT` and `clamp_sticky[clr_ch] = 0` on the next edge.
  - Collision with a stage-2 write to the same channel: the clear wins the state update.
  - The output of that update still reports the computed `mu` and `strobe`.
  - A stage-1 sample for the cleared channel, arriving the following cycle, operates on `MU_INIT`.
- **Range:** `in_ch ≥ NCH` is a protocol error. The sample is dropped, with no state change and no output.

## Timing
- Latency: `in_valid` at edge n → `out_valid` at edge n+2. Throughput is 1 sample/cycle, with any channel order.
- Back-to-back samples on the same channel are hazard-free: the stage-2 read sees the write from the previous edge.
- Reset (asynchronous) sets:
  - every `acc[i] = MU_INIT`;
  - `clamp_sticky = 0`;
  - `valid1`, `out_valid`, `strobe`, `clamp` = 0;
  - `mu = 0`, `out_ch = 0`.
- Reset mid-stream flushes both pipeline stages. No output is produced for samples accepted before reset.
- `step` is sampled in stage 1 together with `v_k`.

## Structure
- Shared package `zcted_timing_pkg` holds:
  - the `ONE(MU_F)` and `HALF(MU_F)` constant functions;
  - the saturating-cast function `sat_u(x, bits)`;
  - the `mu_t` typedef convention.
- One sub-module, `nco_inc_sat`: the combinational shift, add and saturate for stage 1. It is reusable by the single-channel loop.
- Per-channel state is a register array of NCH×MU_F bits plus NCH sticky flags. No RAM is used (NCH is small).

## Test plan
- Nominal step, `NCH = 1`, `step = 256`, `v_k = 0`, from reset (`acc = 154`):
  - 1st sample → `mu = 410`, `strobe = 0`;
  - 2nd sample → `mu = 154`, `strobe = 1`;
  - then alternating.
- Negative saturation, `v_k = -32768`, `step = 256`:
  - `v_s = -512`, `w = -256`, clamped to 0;
  - `mu` stays at 154, `clamp = 1`, `clamp_sticky[0] = 1`, `strobe = 0`.
- Positive saturation, `v_k = +32767`:
  - `v_s = 511`, `w = 767`, clamped to 511;
  - `154 + 511 = 665` → `mu = 153`, `strobe = 1`, `clamp = 1`.
- Four-channel interleave 0,1,2,3,0,… with `v_k` = 0, +64, -64, 0 (`v_s` = 0, +1, -1, 0):
  - after 2 updates per channel, `mu` = 154, 156, 152, 154, each with `strobe = 1`;
  - `out_ch` matches the input order at 2-cycle latency.
- Same channel every cycle, checked against the golden model each cycle:
  - no lost updates;
  - `clr_en` on that channel coincident with a stage-2 write → next result starts from `MU_INIT`;
  - `clamp_sticky` is cleared.
- Assert `rst` mid-stream with both stages full:
  - `out_valid = 0` the same cycle;
  - no stale output after release;
  - all `acc` values return to 154.
